// File: rtl/dcache_pkg.sv
// Shared types and geometry for the direct-mapped write-back data cache.
package dcache_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITEBACK = 2'd1,
    FETCH     = 2'd2
  } dcache_state_t;

  localparam int DC_ADDR_W   = 8;
  localparam int DC_INDEX_W  = 3;
  localparam int DC_DATA_W   = 32;
  localparam int DC_OFFSET_W = 2;
  localparam int INDEX_LSB   = DC_OFFSET_W;

  function automatic int tag_width(input int addr_w, input int index_w);
    return addr_w - DC_OFFSET_W - index_w;
  endfunction

endpackage

// File: rtl/dcache_line_array.sv
// Per-line valid/dirty/tag/data storage: combinational read by index, one
// synchronous write port, asynchronous clear of every line.
module dcache_line_array #(
  parameter int INDEX_W = 3,
  parameter int TAG_W   = 3,
  parameter int DATA_W  = 32
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [INDEX_W-1:0] rd_index,
  output logic               rd_valid,
  output logic               rd_dirty,
  output logic [TAG_W-1:0]   rd_tag,
  output logic [DATA_W-1:0]  rd_data,
  input  logic               wr_en,
  input  logic [INDEX_W-1:0] wr_index,
  input  logic               wr_dirty,
  input  logic [TAG_W-1:0]   wr_tag,
  input  logic [DATA_W-1:0]  wr_data
);

  localparam int LINES = 1 << INDEX_W;

  logic [LINES-1:0]  valid_vec;
  logic [LINES-1:0]  dirty_vec;
  logic [TAG_W-1:0]  tag_vec  [LINES];
  logic [DATA_W-1:0] data_vec [LINES];

  for (genvar gi = 0; gi < LINES; gi++) begin : g_line
    logic              valid_reg;
    logic              dirty_reg;
    logic [TAG_W-1:0]  tag_reg;
    logic [DATA_W-1:0] data_reg;

    always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
        valid_reg <= 1'b0;
        dirty_reg <= 1'b0;
        tag_reg   <= '0;
        data_reg  <= '0;
      end else if (wr_en && (wr_index == INDEX_W'(gi))) begin
        valid_reg <= 1'b1;
        dirty_reg <= wr_dirty;
        tag_reg   <= wr_tag;
        data_reg  <= wr_data;
      end
    end

    assign valid_vec[gi] = valid_reg;
    assign dirty_vec[gi] = dirty_reg;
    assign tag_vec[gi]   = tag_reg;
    assign data_vec[gi]  = data_reg;
  end

  assign rd_valid = valid_vec[rd_index];
  assign rd_dirty = dirty_vec[rd_index];
  assign rd_tag   = tag_vec[rd_index];
  assign rd_data  = data_vec[rd_index];

endmodule

// File: rtl/dcache_controller.sv
// Direct-mapped write-back/write-allocate data cache controller with miss FSM.
// Optional DCACHE_STATS_EN adds saturating hit_count/miss_count outputs.
module dcache_controller
  import dcache_pkg::*;
#(
  parameter int ADDR_W  = DC_ADDR_W,
  parameter int INDEX_W = DC_INDEX_W,
  parameter int DATA_W  = DC_DATA_W,
  localparam int TAG_W      = tag_width(ADDR_W, INDEX_W),
  localparam int MEM_ADDR_W = ADDR_W - DC_OFFSET_W
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  cpu_read,
  input  logic                  cpu_write,
  input  logic [ADDR_W-1:0]     cpu_address,
  input  logic [DATA_W-1:0]     cpu_writedata,
  output logic [DATA_W-1:0]     cpu_readdata,
  output logic                  cpu_busywait,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic [MEM_ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0]     mem_writedata,
  input  logic [DATA_W-1:0]     mem_readdata,
  input  logic                  mem_busywait
`ifdef DCACHE_STATS_EN
  ,
  output logic [15:0]           hit_count,
  output logic [15:0]           miss_count
`endif
);

  dcache_state_t         state_reg;
  logic                  mem_read_reg;
  logic                  mem_write_reg;
  logic [MEM_ADDR_W-1:0] addr_reg;

  logic                  request;
  logic                  is_write;
  logic                  hit;
  logic                  wr_en;
  logic [INDEX_W-1:0]    cpu_index;
  logic [TAG_W-1:0]      cpu_tag;
  logic [INDEX_W-1:0]    line_index;
  logic [TAG_W-1:0]      line_tag;
  logic                  rd_valid;
  logic                  rd_dirty;
  logic [TAG_W-1:0]      rd_tag;
  logic [DATA_W-1:0]     rd_data;
  logic                  unused_offset;

  assign cpu_index     = cpu_address[INDEX_LSB +: INDEX_W];
  assign cpu_tag       = cpu_address[ADDR_W-1 -: TAG_W];
  assign unused_offset = ^cpu_address[INDEX_LSB-1:0];
  assign request       = cpu_read ^ cpu_write;
  assign is_write      = cpu_write & ~cpu_read;

  // Outside IDLE the line is addressed by the latched miss address so a
  // dropped request still completes its fill on the right line.
  assign line_index = (state_reg == IDLE) ? cpu_index : addr_reg[INDEX_W-1:0];
  assign line_tag   = (state_reg == IDLE) ? cpu_tag   : addr_reg[MEM_ADDR_W-1 -: TAG_W];
  assign hit        = rd_valid && (rd_tag == cpu_tag);
  assign wr_en      = (state_reg == IDLE) ? (is_write && hit)
                                          : ((state_reg == FETCH) && !mem_busywait);

  dcache_line_array #(
    .INDEX_W (INDEX_W),
    .TAG_W   (TAG_W),
    .DATA_W  (DATA_W)
  ) u_lines (
    .clock    (clock),
    .reset    (reset),
    .rd_index (line_index),
    .rd_valid (rd_valid),
    .rd_dirty (rd_dirty),
    .rd_tag   (rd_tag),
    .rd_data  (rd_data),
    .wr_en    (wr_en),
    .wr_index (line_index),
    .wr_dirty (state_reg == IDLE),
    .wr_tag   (line_tag),
    .wr_data  ((state_reg == IDLE) ? cpu_writedata : mem_readdata)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_reg     <= IDLE;
      mem_read_reg  <= 1'b0;
      mem_write_reg <= 1'b0;
      addr_reg      <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (request && !hit) begin
            addr_reg <= cpu_address[ADDR_W-1:INDEX_LSB];
            if (rd_valid && rd_dirty) begin
              state_reg     <= WRITEBACK;
              mem_write_reg <= 1'b1;
            end else begin
              state_reg    <= FETCH;
              mem_read_reg <= 1'b1;
            end
          end
        end
        WRITEBACK: begin
          if (!mem_busywait) begin
            state_reg     <= FETCH;
            mem_write_reg <= 1'b0;
            mem_read_reg  <= 1'b1;
          end
        end
        FETCH: begin
          if (!mem_busywait) begin
            state_reg    <= IDLE;
            mem_read_reg <= 1'b0;
          end
        end
        default: begin
          state_reg     <= IDLE;
          mem_read_reg  <= 1'b0;
          mem_write_reg <= 1'b0;
        end
      endcase
    end
  end

  // Gated by reset so the stall releases the instant reset is asserted.
  assign cpu_busywait  = reset && ((state_reg != IDLE) || (request && !hit));
  assign cpu_readdata  = rd_data;
  assign mem_read      = mem_read_reg;
  assign mem_write     = mem_write_reg;
  assign mem_address   = (state_reg == WRITEBACK) ? {rd_tag, addr_reg[INDEX_W-1:0]} : addr_reg;
  assign mem_writedata = rd_data;

`ifdef DCACHE_STATS_EN
  logic [15:0] hit_count_reg;
  logic [15:0] miss_count_reg;
  logic        miss_seen_reg;

  // The hit that retires a filled miss is not a fresh request, so skip it.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      hit_count_reg  <= '0;
      miss_count_reg <= '0;
      miss_seen_reg  <= 1'b0;
    end else if (state_reg == IDLE) begin
      if (request && !hit) begin
        miss_seen_reg <= 1'b1;
        if (miss_count_reg != 16'hFFFF) miss_count_reg <= miss_count_reg + 16'd1;
      end else begin
        if (request && !miss_seen_reg && (hit_count_reg != 16'hFFFF))
          hit_count_reg <= hit_count_reg + 16'd1;
        miss_seen_reg <= 1'b0;
      end
    end
  end

  assign hit_count  = hit_count_reg;
  assign miss_count = miss_count_reg;
`endif

endmodule

// File: tb/tb_dcache_controller.sv
// Self-checking bench for dcache_controller: memory-side scoreboard plus
// per-scenario CPU-side checks of read data and stall length.
module tb_dcache_controller;

  localparam int LAT    = 2;
  localparam int MAXC   = 200;
  localparam int CLEAN  = LAT + 3;
  localparam int DIRTY  = 2 * (LAT + 1) + 2;

  typedef struct {
    logic        wr;
    logic [5:0]  addr;
    logic [31:0] data;
  } mem_txn_t;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        cpu_read = 1'b0;
  logic        cpu_write = 1'b0;
  logic [7:0]  cpu_address = '0;
  logic [31:0] cpu_writedata = '0;
  logic [31:0] cpu_readdata;
  logic        cpu_busywait;
  logic        mem_read;
  logic        mem_write;
  logic [5:0]  mem_address;
  logic [31:0] mem_writedata;
  logic [31:0] mem_readdata;
  logic        mem_busywait;
`ifdef DCACHE_STATS_EN
  logic [15:0] hit_count;
  logic [15:0] miss_count;
`endif

  logic [31:0] mem [64];
  int          mem_cnt = 0;
  mem_txn_t    exp_q[$];
  logic [31:0] rd_q[$];
  int          vectors = 0;
  int          miscompares = 0;

  always #5 clock = ~clock;

  dcache_controller dut (
    .clock         (clock),
    .reset         (reset),
    .cpu_read      (cpu_read),
    .cpu_write     (cpu_write),
    .cpu_address   (cpu_address),
    .cpu_writedata (cpu_writedata),
    .cpu_readdata  (cpu_readdata),
    .cpu_busywait  (cpu_busywait),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .mem_address   (mem_address),
    .mem_writedata (mem_writedata),
    .mem_readdata  (mem_readdata),
    .mem_busywait  (mem_busywait)
`ifdef DCACHE_STATS_EN
    ,
    .hit_count     (hit_count),
    .miss_count    (miss_count)
`endif
  );

  function automatic logic [31:0] init_word(input int i);
    if (i == 2)  return 32'h1122_3344;
    if (i == 10) return 32'hA5A5_0A0A;
    return 32'h1000_0000 + 32'(i);
  endfunction

  // Memory: busy for LAT cycles after a request, completes on the next edge.
  assign mem_busywait = (mem_read | mem_write) && (mem_cnt != LAT);
  assign mem_readdata = mem[mem_address];

  always @(posedge clock) begin
    if (mem_read | mem_write) begin
      if (mem_cnt == LAT) begin
        mem_cnt <= 0;
        if (mem_write) mem[mem_address] <= mem_writedata;
      end else begin
        mem_cnt <= mem_cnt + 1;
      end
    end else begin
      mem_cnt <= 0;
    end
  end

  // Scoreboard for the memory side: each completing transaction pops one expectation.
  always @(negedge clock) begin
    if (reset) begin
      if (mem_read && mem_write) begin
        vectors++;
        miscompares++;
        $display("FAIL mem_excl: mem_read and mem_write both high at %0t", $time);
      end
      if ((mem_read | mem_write) && !mem_busywait) begin
        $display("mem %s addr=%02h data=%08h", mem_write ? "write" : "read ", mem_address,
                 mem_write ? mem_writedata : mem_readdata);
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL mem_unexpected: got wr=%0b addr=%02h, required no transaction",
                   mem_write, mem_address);
        end else begin
          mem_txn_t e;
          e = exp_q.pop_front();
          if (e.wr !== mem_write || e.addr !== mem_address ||
              (e.wr && e.data !== mem_writedata)) begin
            miscompares++;
            $display("FAIL mem_txn: got wr=%0b addr=%02h data=%08h, required wr=%0b addr=%02h data=%08h",
                     mem_write, mem_address, mem_writedata, e.wr, e.addr, e.data);
          end
        end
      end
    end
  end

  task automatic push_mem(input logic wr, input logic [5:0] a, input logic [31:0] d);
    mem_txn_t t;
    t.wr = wr; t.addr = a; t.data = d;
    exp_q.push_back(t);
  endtask

  task automatic cpu_access(input logic rd, input logic wr, input logic [7:0] a,
                            input logic [31:0] wd, output logic [31:0] rdata, output int cycles);
    @(negedge clock);
    cpu_read = rd; cpu_write = wr; cpu_address = a; cpu_writedata = wd;
    cycles = 1;
    #1;
    while (cpu_busywait && cycles < MAXC) begin
      @(negedge clock);
      #1;
      cycles++;
    end
    if (cpu_busywait) begin
      vectors++;
      miscompares++;
      $display("FAIL cpu_timeout: busywait still 1 after %0d cycles, required 0", cycles);
    end
    rdata = cpu_readdata;
    $display("cpu %s addr=%02h wdata=%08h rdata=%08h cycles=%0d", wr ? "write" : "read ",
             a, wd, rdata, cycles);
    @(posedge clock);
    #1;
    cpu_read = 1'b0; cpu_write = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    vectors += 4;
    if (cpu_busywait !== 1'b0) begin miscompares++; $display("FAIL rst_busy: got %0b required 0", cpu_busywait); end
    if (mem_read !== 1'b0)     begin miscompares++; $display("FAIL rst_mrd: got %0b required 0", mem_read); end
    if (mem_write !== 1'b0)    begin miscompares++; $display("FAIL rst_mwr: got %0b required 0", mem_write); end
    if (cpu_readdata !== 32'h0) begin miscompares++; $display("FAIL rst_rdata: got %08h required 0", cpu_readdata); end
    reset = 1'b1;
  endtask

  task automatic test_read_miss();
    logic [31:0] r; logic [31:0] e; int c;
    push_mem(1'b0, 6'h02, 32'h0);
    rd_q.push_back(32'h1122_3344);
    cpu_access(1'b1, 1'b0, 8'h08, 32'h0, r, c);
    e = rd_q.pop_front();
    vectors += 2;
    if (r !== e)     begin miscompares++; $display("FAIL rdmiss_data: got %08h required %08h", r, e); end
    if (c != CLEAN)  begin miscompares++; $display("FAIL rdmiss_cycles: got %0d required %0d", c, CLEAN); end
  endtask

  task automatic test_read_hit();
    logic [31:0] r; logic [31:0] e; int c;
    rd_q.push_back(32'h1122_3344);
    cpu_access(1'b1, 1'b0, 8'h08, 32'h0, r, c);
    e = rd_q.pop_front();
    vectors += 2;
    if (r !== e) begin miscompares++; $display("FAIL rdhit_data: got %08h required %08h", r, e); end
    if (c != 1)  begin miscompares++; $display("FAIL rdhit_cycles: got %0d required 1", c); end
  endtask

  task automatic test_write_hit();
    logic [31:0] r; logic [31:0] e; int c;
    cpu_access(1'b0, 1'b1, 8'h08, 32'hDEAD_BEEF, r, c);
    vectors++;
    if (c != 1) begin miscompares++; $display("FAIL wrhit_cycles: got %0d required 1", c); end
    rd_q.push_back(32'hDEAD_BEEF);
    cpu_access(1'b1, 1'b0, 8'h08, 32'h0, r, c);
    e = rd_q.pop_front();
    vectors += 2;
    if (r !== e) begin miscompares++; $display("FAIL wrhit_read: got %08h required %08h", r, e); end
    if (c != 1)  begin miscompares++; $display("FAIL wrhit_rdcycles: got %0d required 1", c); end
  endtask

  task automatic test_writeback();
    logic [31:0] r; logic [31:0] e; int c;
    push_mem(1'b1, 6'h02, 32'hDEAD_BEEF);
    push_mem(1'b0, 6'h0A, 32'h0);
    rd_q.push_back(32'hA5A5_0A0A);
    cpu_access(1'b1, 1'b0, 8'h28, 32'h0, r, c);
    e = rd_q.pop_front();
    vectors += 3;
    if (r !== e)       begin miscompares++; $display("FAIL wb_data: got %08h required %08h", r, e); end
    if (c != DIRTY)    begin miscompares++; $display("FAIL wb_cycles: got %0d required %0d", c, DIRTY); end
    if (mem[2] !== 32'hDEAD_BEEF) begin miscompares++; $display("FAIL wb_memword: got %08h required deadbeef", mem[2]); end
  endtask

  task automatic test_write_miss();
    logic [31:0] r; logic [31:0] e; int c;
    push_mem(1'b0, 6'h03, 32'h0);
    cpu_access(1'b0, 1'b1, 8'h0C, 32'hCAFE_F00D, r, c);
    vectors++;
    if (c != CLEAN) begin miscompares++; $display("FAIL wrmiss_cycles: got %0d required %0d", c, CLEAN); end
    rd_q.push_back(32'hCAFE_F00D);
    cpu_access(1'b1, 1'b0, 8'h0C, 32'h0, r, c);
    e = rd_q.pop_front();
    vectors += 2;
    if (r !== e) begin miscompares++; $display("FAIL wrmiss_merge: got %08h required %08h", r, e); end
    if (c != 1)  begin miscompares++; $display("FAIL wrmiss_hitcycles: got %0d required 1", c); end
    // Evicting line 3 must write the merged store back, proving it went dirty.
    push_mem(1'b1, 6'h03, 32'hCAFE_F00D);
    push_mem(1'b0, 6'h0B, 32'h0);
    rd_q.push_back(init_word(11));
    cpu_access(1'b1, 1'b0, 8'h2C, 32'h0, r, c);
    e = rd_q.pop_front();
    vectors += 2;
    if (r !== e)    begin miscompares++; $display("FAIL wrmiss_evict: got %08h required %08h", r, e); end
    if (c != DIRTY) begin miscompares++; $display("FAIL wrmiss_evcycles: got %0d required %0d", c, DIRTY); end
  endtask

  task automatic test_both_high();
    @(negedge clock);
    cpu_read = 1'b1; cpu_write = 1'b1; cpu_address = 8'h30; cpu_writedata = 32'h5555_AAAA;
    for (int i = 0; i < 3; i++) begin
      #1;
      vectors++;
      if (cpu_busywait !== 1'b0 || mem_read !== 1'b0 || mem_write !== 1'b0) begin
        miscompares++;
        $display("FAIL both_high: got busy=%0b mrd=%0b mwr=%0b required 0/0/0",
                 cpu_busywait, mem_read, mem_write);
      end
      $display("cpu both  addr=30 cycle=%0d busy=%0b", i, cpu_busywait);
      @(negedge clock);
    end
    cpu_read = 1'b0; cpu_write = 1'b0;
  endtask

  task automatic test_reset_fetch();
    logic [31:0] r; logic [31:0] e; int c; int n;
    @(negedge clock);
    cpu_read = 1'b1; cpu_address = 8'h08;
    n = 0;
    while (!mem_read && n < 20) begin @(negedge clock); n++; end
    vectors++;
    if (!mem_read) begin miscompares++; $display("FAIL rstf_start: mem_read got 0 required 1"); end
    #2;
    reset = 1'b0;
    #1;
    vectors += 3;
    if (mem_read !== 1'b0)      begin miscompares++; $display("FAIL rstf_mrd: got %0b required 0", mem_read); end
    if (cpu_busywait !== 1'b0)  begin miscompares++; $display("FAIL rstf_busy: got %0b required 0", cpu_busywait); end
    if (cpu_readdata !== 32'h0) begin miscompares++; $display("FAIL rstf_rdata: got %08h required 0", cpu_readdata); end
    $display("reset asserted during fetch");
    cpu_read = 1'b0;
    exp_q.delete();
    repeat (2) @(negedge clock);
    reset = 1'b1;
    push_mem(1'b0, 6'h02, 32'h0);
    rd_q.push_back(32'hDEAD_BEEF);
    cpu_access(1'b1, 1'b0, 8'h08, 32'h0, r, c);
    e = rd_q.pop_front();
    vectors += 2;
    if (r !== e)    begin miscompares++; $display("FAIL rstf_reread: got %08h required %08h", r, e); end
    if (c != CLEAN) begin miscompares++; $display("FAIL rstf_cycles: got %0d required %0d", c, CLEAN); end
  endtask

  task automatic test_back_to_back();
    logic [7:0]  addrs [5] = '{8'h1C, 8'hFC, 8'h1C, 8'hFC, 8'h1C};
    logic        wrs   [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic [31:0] r; logic [31:0] e; int c; int exp_c;
    for (int i = 0; i < 5; i++) begin
      exp_c = CLEAN;
      if (i == 4) begin
        push_mem(1'b1, 6'h3F, 32'h7777_0000);
        exp_c = DIRTY;
      end
      push_mem(1'b0, addrs[i][7:2], 32'h0);
      if (!wrs[i]) rd_q.push_back(init_word(int'(addrs[i][7:2])));
      cpu_access(!wrs[i], wrs[i], addrs[i], 32'h7777_0000, r, c);
      vectors++;
      if (c != exp_c) begin miscompares++; $display("FAIL b2b_cycles[%0d]: got %0d required %0d", i, c, exp_c); end
      if (!wrs[i]) begin
        e = rd_q.pop_front();
        vectors++;
        if (r !== e) begin miscompares++; $display("FAIL b2b_data[%0d]: got %08h required %08h", i, r, e); end
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = init_word(i);
    test_reset();
    test_read_miss();
    test_read_hit();
    test_write_hit();
    test_writeback();
    test_write_miss();
    test_both_high();
    test_reset_fetch();
    test_back_to_back();
    repeat (4) @(negedge clock);
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL mem_pending: got %0d outstanding transactions required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
